// File: rtl/axis_bridge_pkg.sv
// Shared definitions for the stream-to-AXI write bridge: header layout, FSM states, AXI response codes.
// ST_DRAIN exists only when S2A_LEN_CHECK_EN is defined.
package axis_bridge_pkg;

   // Header fields sit directly above the address; offsets are relative to ADDR_WIDTH.
   localparam int HDR_LEN_OFS   = 0;
   localparam int HDR_LEN_W     = 8;
   localparam int HDR_SIZE_OFS  = 8;
   localparam int HDR_SIZE_W    = 3;
   localparam int HDR_BURST_OFS = 11;
   localparam int HDR_BURST_W   = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
`ifdef S2A_LEN_CHECK_EN
      ST_DRAIN,
`endif
      ST_RESP
   } axi_wr_state_e;

endpackage

// File: rtl/stream_to_axi_writer.sv
// Stream-to-AXI4 write bridge: header beat loads AW, following beats pass through to W, then waits for B.
// Build option S2A_LEN_CHECK_EN adds tlast/awlen mismatch handling (zero-strobe padding or DRAIN).
module stream_to_axi_writer
   import axis_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 64,
   parameter int ID_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   stream_tdata,
   input  logic [DATA_WIDTH/8-1:0] stream_tkeep,
   input  logic [ID_WIDTH-1:0]     stream_tid,
   input  logic                    stream_tlast,
   input  logic                    stream_tvalid,
   output logic                    stream_tready,
   output logic [ID_WIDTH-1:0]     AXIM_awid,
   output logic [ADDR_WIDTH-1:0]   AXIM_awaddr,
   output logic [7:0]              AXIM_awlen,
   output logic [2:0]              AXIM_awsize,
   output logic [1:0]              AXIM_awburst,
   output logic                    AXIM_awvalid,
   input  logic                    AXIM_awready,
   output logic [DATA_WIDTH-1:0]   AXIM_wdata,
   output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
   output logic                    AXIM_wlast,
   output logic                    AXIM_wvalid,
   input  logic                    AXIM_wready,
   input  logic [1:0]              AXIM_bresp,
   input  logic                    AXIM_bvalid,
   output logic                    AXIM_bready,
   output logic                    err,
   output logic                    done
);

   axi_wr_state_e           state_q, state_d;
   logic [ID_WIDTH-1:0]     awid_q, awid_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [7:0]              awlen_q, awlen_d;
   logic [2:0]              awsize_q, awsize_d;
   logic [1:0]              awburst_q, awburst_d;
   logic [8:0]              cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic                    done_q, done_d;
`ifdef S2A_LEN_CHECK_EN
   logic                    pad_q, pad_d;
`else
   logic                    unused_tlast;
   assign unused_tlast = stream_tlast;
`endif

   logic                    tready_c, awvalid_c, wvalid_c, wlast_c, bready_c;
   logic [DATA_WIDTH-1:0]   wdata_c;
   logic [DATA_WIDTH/8-1:0] wstrb_c;
   logic                    beat_last;

   assign beat_last = (cnt_q == {1'b0, awlen_q});

   always_comb begin
      state_d   = state_q;
      awid_d    = awid_q;
      awaddr_d  = awaddr_q;
      awlen_d   = awlen_q;
      awsize_d  = awsize_q;
      awburst_d = awburst_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      done_d    = 1'b0;
      tready_c  = 1'b0;
      awvalid_c = 1'b0;
      wvalid_c  = 1'b0;
      wlast_c   = 1'b0;
      wdata_c   = '0;
      wstrb_c   = '0;
      bready_c  = 1'b0;
`ifdef S2A_LEN_CHECK_EN
      pad_d     = pad_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tready_c = 1'b1;
            if (stream_tvalid) begin
               awid_d    = stream_tid;
               awaddr_d  = stream_tdata[ADDR_WIDTH-1:0];
               awlen_d   = stream_tdata[ADDR_WIDTH+HDR_LEN_OFS +: HDR_LEN_W];
               awsize_d  = stream_tdata[ADDR_WIDTH+HDR_SIZE_OFS +: HDR_SIZE_W];
               awburst_d = stream_tdata[ADDR_WIDTH+HDR_BURST_OFS +: HDR_BURST_W];
               cnt_d     = '0;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: begin
            awvalid_c = 1'b1;
            if (AXIM_awready) state_d = ST_DATA;
         end
         ST_DATA: begin
            wlast_c = beat_last;
`ifdef S2A_LEN_CHECK_EN
            // Packet ended early: finish the burst with null-strobe beats, stream held off.
            if (pad_q) begin
               wvalid_c = 1'b1;
               if (AXIM_wready) begin
                  if (beat_last) begin
                     pad_d   = 1'b0;
                     state_d = ST_RESP;
                  end else begin
                     cnt_d = cnt_q + 9'd1;
                  end
               end
            end else begin
`endif
               wvalid_c = stream_tvalid;
               tready_c = AXIM_wready;
               wdata_c  = stream_tdata;
               wstrb_c  = stream_tkeep;
               if (stream_tvalid && AXIM_wready) begin
                  if (beat_last) begin
                     state_d = ST_RESP;
`ifdef S2A_LEN_CHECK_EN
                     if (!stream_tlast) state_d = ST_DRAIN;
`endif
                  end else begin
                     cnt_d = cnt_q + 9'd1;
`ifdef S2A_LEN_CHECK_EN
                     if (stream_tlast) begin
                        err_d = 1'b1;
                        pad_d = 1'b1;
                     end
`endif
                  end
               end
`ifdef S2A_LEN_CHECK_EN
            end
`endif
         end
`ifdef S2A_LEN_CHECK_EN
         // Burst already complete on AXI; swallow the packet tail.
         ST_DRAIN: begin
            tready_c = 1'b1;
            if (stream_tvalid && stream_tlast) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
`endif
         ST_RESP: begin
            bready_c = 1'b1;
            if (AXIM_bvalid) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               if (AXIM_bresp != RESP_OKAY) err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         awid_q    <= '0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         awburst_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef S2A_LEN_CHECK_EN
         pad_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         awid_q    <= awid_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         awsize_q  <= awsize_d;
         awburst_q <= awburst_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
`ifdef S2A_LEN_CHECK_EN
         pad_q     <= pad_d;
`endif
      end
   end

   // State is forced to IDLE by reset, so only the IDLE-asserted tready needs explicit gating.
   assign stream_tready = tready_c & ~reset;
   assign AXIM_awid     = awid_q;
   assign AXIM_awaddr   = awaddr_q;
   assign AXIM_awlen    = awlen_q;
   assign AXIM_awsize   = awsize_q;
   assign AXIM_awburst  = awburst_q;
   assign AXIM_awvalid  = awvalid_c;
   assign AXIM_wdata    = wdata_c;
   assign AXIM_wstrb    = wstrb_c;
   assign AXIM_wlast    = wlast_c;
   assign AXIM_wvalid   = wvalid_c;
   assign AXIM_bready   = bready_c;
   assign err           = err_q;
   assign done          = done_q;

endmodule

// File: tb/tb_stream_to_axi_writer.sv
// Directed bench for stream_to_axi_writer: fixed bursts, len=0, error stickiness, mid-burst reset,
// tlast length mismatch (behaviour follows S2A_LEN_CHECK_EN), then 100 packets under random stalls.
module tb_stream_to_axi_writer;
   import axis_bridge_pkg::*;

   localparam int DW = 128;
   localparam int AW = 64;
   localparam int IW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] stream_tdata;
   logic [SW-1:0] stream_tkeep;
   logic [IW-1:0] stream_tid;
   logic          stream_tlast, stream_tvalid, stream_tready;
   logic [IW-1:0] AXIM_awid;
   logic [AW-1:0] AXIM_awaddr;
   logic [7:0]    AXIM_awlen;
   logic [2:0]    AXIM_awsize;
   logic [1:0]    AXIM_awburst;
   logic          AXIM_awvalid;
   logic          AXIM_awready = 1'b0;
   logic [DW-1:0] AXIM_wdata;
   logic [SW-1:0] AXIM_wstrb;
   logic          AXIM_wlast, AXIM_wvalid;
   logic          AXIM_wready = 1'b0;
   logic [1:0]    AXIM_bresp = 2'b00;
   logic          AXIM_bvalid = 1'b0;
   logic          AXIM_bready, err, done;

   stream_to_axi_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .clk(clk), .reset(reset),
      .stream_tdata(stream_tdata), .stream_tkeep(stream_tkeep), .stream_tid(stream_tid),
      .stream_tlast(stream_tlast), .stream_tvalid(stream_tvalid), .stream_tready(stream_tready),
      .AXIM_awid(AXIM_awid), .AXIM_awaddr(AXIM_awaddr), .AXIM_awlen(AXIM_awlen),
      .AXIM_awsize(AXIM_awsize), .AXIM_awburst(AXIM_awburst),
      .AXIM_awvalid(AXIM_awvalid), .AXIM_awready(AXIM_awready),
      .AXIM_wdata(AXIM_wdata), .AXIM_wstrb(AXIM_wstrb), .AXIM_wlast(AXIM_wlast),
      .AXIM_wvalid(AXIM_wvalid), .AXIM_wready(AXIM_wready),
      .AXIM_bresp(AXIM_bresp), .AXIM_bvalid(AXIM_bvalid), .AXIM_bready(AXIM_bready),
      .err(err), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [DW-1:0] d; logic [SW-1:0] s; logic l; bit chk_d; } wbeat_t;
   typedef struct { logic [AW-1:0] a; logic [7:0] l; logic [2:0] sz; logic [1:0] b; logic [IW-1:0] id; } aw_t;

   wbeat_t w_log[$], exp_w[$];
   aw_t    aw_log[$], exp_aw[$];
   int     n_tests = 0, n_fail = 0;
   int     cyc = 0, done_cnt = 0, b_pend = 0, b_cyc = -10, done_cyc = -10, aw_unstable = 0;
   bit     stall = 1'b0;
   logic [1:0] resp_code = 2'b00;
   logic   bvalid_nxt = 1'b0;
   logic   aw_wait = 1'b0;
   aw_t    aw_prev;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // AXI slave model and monitor, sampled away from the rising edge.
   always @(negedge clk) begin : mon
      logic   b_hs;
      wbeat_t wb;
      b_hs = AXIM_bvalid && AXIM_bready;
      if (AXIM_awvalid) begin
         if (aw_wait && (AXIM_awaddr !== aw_prev.a || AXIM_awlen !== aw_prev.l ||
                         AXIM_awsize !== aw_prev.sz || AXIM_awburst !== aw_prev.b ||
                         AXIM_awid !== aw_prev.id))
            aw_unstable++;
         aw_prev.a  = AXIM_awaddr;
         aw_prev.l  = AXIM_awlen;
         aw_prev.sz = AXIM_awsize;
         aw_prev.b  = AXIM_awburst;
         aw_prev.id = AXIM_awid;
         aw_wait    = !AXIM_awready;
         if (AXIM_awready) aw_log.push_back(aw_prev);
      end else begin
         aw_wait = 1'b0;
      end
      if (AXIM_wvalid && AXIM_wready) begin
         wb.d = AXIM_wdata;
         wb.s = AXIM_wstrb;
         wb.l = AXIM_wlast;
         wb.chk_d = 1'b1;
         w_log.push_back(wb);
         if (AXIM_wlast) b_pend++;
      end
      if (b_hs) begin
         b_pend--;
         b_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (AXIM_bvalid && !b_hs) bvalid_nxt = 1'b1;
      else bvalid_nxt = (b_pend > 0) && (!stall || $urandom_range(0, 1) == 1);
   end

   always @(posedge clk) begin
      cyc++;
      #1;
      AXIM_awready = !stall || $urandom_range(0, 1) == 1;
      AXIM_wready  = !stall || $urandom_range(0, 1) == 1;
      AXIM_bvalid  = bvalid_nxt;
      AXIM_bresp   = resp_code;
   end

   function automatic logic [DW-1:0] mk_hdr(input logic [AW-1:0] a, input logic [7:0] l,
                                           input logic [2:0] s, input logic [1:0] b);
      logic [DW-1:0] h;
      h = '0;
      h[127:96] = 32'hDEAD_BEEF;
      h[63:0]   = a;
      h[71:64]  = l;
      h[74:72]  = s;
      h[76:75]  = b;
      return h;
   endfunction

   task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] k, input logic l,
                            input logic [IW-1:0] id, output bit ok);
      int t;
      t = 0;
      ok = 1'b0;
      stream_tdata = d; stream_tkeep = k; stream_tlast = l; stream_tid = id; stream_tvalid = 1'b1;
      while (!ok && t < 500) begin
         @(negedge clk);
         if (stream_tready) ok = 1'b1;
         @(posedge clk); #1;
         t++;
      end
      stream_tvalid = 1'b0;
      if (!ok) chk("beat_timeout", 0, 1);
   endtask

   task automatic send_pkt(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [IW-1:0] id, input int nbeats,
                           input int tlast_at, input bit rnd);
      bit ok;
      aw_t e;
      wbeat_t wb;
      e.a = a; e.l = len; e.sz = sz; e.b = bu; e.id = id;
      exp_aw.push_back(e);
      send_beat(mk_hdr(a, len, sz, bu), '1, 1'b0, id, ok);
      if (!ok) return;
      for (int i = 0; i < nbeats; i++) begin
         if (rnd && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         wb.d = {$urandom, $urandom, $urandom, $urandom};
         wb.s = rnd ? SW'($urandom) : '1;
         wb.l = (i == int'(len));
         wb.chk_d = 1'b1;
         exp_w.push_back(wb);
         send_beat(wb.d, wb.s, (i == tlast_at), 32'hFFFF_FFFF, ok);
         if (!ok) return;
      end
   endtask

   task automatic wait_done(input int target);
      int t;
      t = 0;
      while (done_cnt < target && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("done_wait", done_cnt, target);
   endtask

   task automatic cmp_w(input string tag);
      chk({tag, "_nbeats"}, w_log.size(), exp_w.size());
      for (int i = 0; i < w_log.size() && i < exp_w.size(); i++) begin
         if (exp_w[i].chk_d) chk($sformatf("%s_wdata%0d", tag, i), w_log[i].d, exp_w[i].d);
         chk($sformatf("%s_wstrb%0d", tag, i), w_log[i].s, exp_w[i].s);
         chk($sformatf("%s_wlast%0d", tag, i), w_log[i].l, exp_w[i].l);
      end
   endtask

   task automatic clear_logs();
      w_log.delete(); exp_w.delete(); aw_log.delete(); exp_aw.delete();
   endtask

   initial begin : main
      int base;
      wbeat_t pb;
      reset = 1'b1;
      stream_tvalid = 1'b1; stream_tdata = '1; stream_tkeep = '1; stream_tid = '1; stream_tlast = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", stream_tready, 0);
      chk("rst_awvalid", AXIM_awvalid, 0);
      chk("rst_wvalid", AXIM_wvalid, 0);
      chk("rst_bready", AXIM_bready, 0);
      chk("rst_err", err, 0);
      chk("rst_done", done, 0);
      chk("rst_awaddr", AXIM_awaddr, 0);
      chk("rst_awlen", AXIM_awlen, 0);
      chk("rst_awid", AXIM_awid, 0);
      chk("rst_wlast", AXIM_wlast, 0);
      @(posedge clk); #1;
      stream_tvalid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      // Fixed burst: addr 0x1000, len 3, size 4, INCR.
      clear_logs();
      send_pkt(64'h1000, 8'd3, 3'd4, 2'b01, 32'h55, 4, 3, 1'b0);
      wait_done(1);
      chk("t1_aw_n", aw_log.size(), 1);
      if (aw_log.size() > 0) begin
         chk("t1_awaddr", aw_log[0].a, 64'h1000);
         chk("t1_awlen", aw_log[0].l, 3);
         chk("t1_awsize", aw_log[0].sz, 4);
         chk("t1_awburst", aw_log[0].b, 1);
         chk("t1_awid", aw_log[0].id, 32'h55);
      end
      cmp_w("t1");
      chk("t1_done_lat", done_cyc - b_cyc, 1);
      repeat (3) @(posedge clk); #1;
      chk("t1_done_pulses", done_cnt, 1);

      // len=0 single beat.
      clear_logs();
      send_pkt(64'h2040, 8'd0, 3'd4, 2'b01, 32'h7, 1, 0, 1'b0);
      wait_done(2);
      cmp_w("t2");
      chk("t2_err", err, 0);

      // SLVERR sticks across a following OKAY burst.
      resp_code = RESP_SLVERR;
      send_pkt(64'h3000, 8'd1, 3'd4, 2'b01, 32'h8, 2, 1, 1'b0);
      wait_done(3);
      chk("t3_err_set", err, 1);
      resp_code = RESP_OKAY;
      send_pkt(64'h3100, 8'd1, 3'd4, 2'b01, 32'h9, 2, 1, 1'b0);
      wait_done(4);
      chk("t3_err_sticky", err, 1);

      // Reset mid-DATA after two beats, then a normal len=1 packet.
      clear_logs();
      send_pkt(64'h4000, 8'd3, 3'd4, 2'b01, 32'hA, 2, -1, 1'b0);
      stream_tvalid = 1'b1; stream_tdata = '1; stream_tkeep = '1;
      #2 reset = 1'b1;
      #1;
      chk("t4_tready", stream_tready, 0);
      chk("t4_wvalid", AXIM_wvalid, 0);
      chk("t4_wlast", AXIM_wlast, 0);
      chk("t4_awvalid", AXIM_awvalid, 0);
      chk("t4_bready", AXIM_bready, 0);
      chk("t4_err", err, 0);
      chk("t4_awaddr", AXIM_awaddr, 0);
      chk("t4_wstrb", AXIM_wstrb, 0);
      repeat (2) @(posedge clk); #1;
      reset = 1'b0; stream_tvalid = 1'b0;
      cmp_w("t4_pre");
      clear_logs();
      send_pkt(64'h5000, 8'd1, 3'd4, 2'b01, 32'hB, 2, 1, 1'b0);
      wait_done(5);
      cmp_w("t4_post");
      chk("t4_post_awaddr", (aw_log.size() > 0) ? aw_log[0].a : 64'hX, 64'h5000);
      chk("t4_post_err", err, 0);

      // len=3 with tlast on beat 2.
      clear_logs();
`ifdef S2A_LEN_CHECK_EN
      send_pkt(64'h6000, 8'd3, 3'd4, 2'b01, 32'hC, 2, 1, 1'b0);
      pb.d = '0; pb.s = '0; pb.chk_d = 1'b0;
      pb.l = 1'b0; exp_w.push_back(pb);
      pb.l = 1'b1; exp_w.push_back(pb);
      wait_done(6);
      cmp_w("t5");
      chk("t5_err", err, 1);
`else
      pb.d = '0;
      send_pkt(64'h6000, 8'd3, 3'd4, 2'b01, 32'hC, 4, 1, 1'b0);
      wait_done(6);
      cmp_w("t5");
      chk("t5_err", err, pb.d[0]);
`endif

      // 100 packets with random stalls on every channel.
      clear_logs();
      stall = 1'b1;
      base = done_cnt;
      for (int p = 0; p < 100; p++) begin
         int len;
         len = $urandom_range(0, 7);
         send_pkt({$urandom, $urandom}, 8'(len), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                  $urandom, len + 1, len, 1'b1);
      end
      wait_done(base + 100);
      stall = 1'b0;
      cmp_w("t6");
      chk("t6_aw_n", aw_log.size(), exp_aw.size());
      for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++) begin
         chk($sformatf("t6_awaddr%0d", i), aw_log[i].a, exp_aw[i].a);
         chk($sformatf("t6_awctl%0d", i), {aw_log[i].l, aw_log[i].sz, aw_log[i].b},
             {exp_aw[i].l, exp_aw[i].sz, exp_aw[i].b});
         chk($sformatf("t6_awid%0d", i), aw_log[i].id, exp_aw[i].id);
      end
      chk("aw_stable", aw_unstable, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stream_to_axi_writer.md
STREAM_TO_AXI_WRITER -- requirements
Module: stream_to_axi_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, data beat width; values 64, 128 or 256 only.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-003 SHALL have parameter ID_WIDTH, default 32, AXI ID width.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- stream_tdata  in  DATA_WIDTH  header or write data.
- stream_tkeep  in  DATA_WIDTH/8  byte valid; becomes wstrb.
- stream_tid  in  ID_WIDTH  transaction ID, sampled on header.
- stream_tlast  in  1  last data beat of packet.
- stream_tvalid  in  1  beat valid.
- stream_tready  out  1  beat accepted.
- AXIM_awid  out  ID_WIDTH  registered tid.
- AXIM_awaddr  out  ADDR_WIDTH  from header.
- AXIM_awlen  out  8  from header.
- AXIM_awsize  out  3  from header.
- AXIM_awburst  out  2  from header.
- AXIM_awvalid / AXIM_awready  out/in  1  AW handshake.
- AXIM_wdata  out  DATA_WIDTH  stream_tdata passthrough.
- AXIM_wstrb  out  DATA_WIDTH/8  stream_tkeep passthrough.
- AXIM_wlast  out  1  counter-derived last beat.
- AXIM_wvalid / AXIM_wready  out/in  1  W handshake.
- AXIM_bresp  in  2  write response.
- AXIM_bvalid / AXIM_bready  in/out  1  B handshake.
- err  out  1  sticky error flag.
- done  out  1  one-cycle pulse per completed burst.

Function
REQ-005 SHALL treat the first beat of each packet as a header: [ADDR_WIDTH-1:0] addr, next 8 bits len, next 3 size, next 2 burst; remaining bits ignored.
REQ-006 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE: stream_tready=1; header accepted -> ADDR.
- ADDR: awvalid=1 until awready -> DATA.
- DATA: wvalid=stream_tvalid, stream_tready=wready; no combinational path from wready to wvalid.
- RESP: bready=1; bvalid -> IDLE.
REQ-007 SHALL take the AW fields from registers loaded on the header handshake; they stay stable while awvalid=1.
REQ-008 SHALL count W beats with a 9-bit counter; wlast=1 when count==awlen; the wlast handshake -> RESP.
REQ-009 SHALL pulse done for one cycle on the B handshake; bresp!=OKAY sets err.
REQ-010 SHALL hold stream_tready=0 in ADDR and RESP; no header is accepted before the previous B completes.
REQ-011 SHALL accept back-to-back packets: header handshake in the cycle after RESP->IDLE.
REQ-012 SHALL treat awlen=0 as a single beat with wlast=1.

Reset
REQ-013 SHALL drive every output to 0 while reset=1 (stream_tready, awvalid, wvalid, bready, err, done, all AW fields) and hold state IDLE.
REQ-014 SHALL abandon any in-flight burst on reset with no further beats issued; err clears only on reset.

Configuration
REQ-015 SHALL compile a length check under macro S2A_LEN_CHECK_EN.
- Defined: tlast on a beat where count!=awlen sets err. An early tlast pads the remaining beats with wstrb=0 and stream_tready=0. A late tlast (tlast=0 on the wlast beat) enters DRAIN, which sinks beats with stream_tready=1 until tlast, then goes to RESP.
- Undefined: tlast is ignored and no DRAIN state exists.

Structure
REQ-016 SHALL put header field offsets/widths, the FSM state enum and the OKAY/SLVERR codes in shared package axis_bridge_pkg.
REQ-017 SHALL be a single module; no sub-modules.

Verification
REQ-018 Header addr=0x1000, len=3, size=4, burst=INCR, then 4 beats with tlast on the 4th -> AW fields exact; 4 W beats; wlast on beat 4; done one cycle after bvalid.
REQ-019 len=0 with a single tlast beat -> one W beat with wlast=1; err=0.
REQ-020 bresp=SLVERR -> err=1 and stays 1 across the next OKAY burst.
REQ-021 With S2A_LEN_CHECK_EN, len=3 and tlast on beat 2 -> err=1; beats 3-4 have wstrb=0; B still completes.
REQ-022 reset asserted mid-DATA after beat 2 -> all outputs 0 immediately; a following len=1 packet completes normally.
REQ-023 Random wready/awready/bvalid stalls at 50% over 100 packets -> data order preserved; no beat dropped or duplicated.
